// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//
// Fetch stage that sits directly behind program_counter. The stage accepts one
// PC at a time. For each PC it issues one instruction-memory read over a
// req/gnt/rvalid handshake. Each result is buffered as {pc, instr, fault} in a
// small FIFO that feeds the decode stage. A PC that is not word aligned never
// reaches memory: it is queued at once with fault=1 and instr=0. A flush
// (branch redirect) empties the queue and discards any read that is still in
// flight.
//
// Vectors are big-endian [0:W-1], so index W-1 is the LSB.
//
// Ports
//   i_clk          clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_pc_in        PC to fetch
//   i_pc_valid     i_pc_in valid
//   o_pc_ready     stage accepts i_pc_in this cycle
//   o_imem_req     memory read request (registered)
//   o_imem_addr    memory read address, stable while o_imem_req=1
//   i_imem_gnt     request accepted by memory
//   i_imem_rvalid  read data valid
//   i_imem_rdata   read data
//   i_flush        discard all queued and in-flight fetches
//   o_if_valid     queue head valid
//   o_if_pc        PC of queue head
//   o_if_instr     instruction of queue head (0 when faulted)
//   o_if_fault     queue head PC was misaligned
//   i_if_ready     decode consumes head when o_if_valid & i_if_ready
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [0:ADDR_W-1] i_pc_in,
    input  logic              i_pc_valid,
    output logic              o_pc_ready,
    output logic              o_imem_req,
    output logic [0:ADDR_W-1] o_imem_addr,
    input  logic              i_imem_gnt,
    input  logic              i_imem_rvalid,
    input  logic [0:DATA_W-1] i_imem_rdata,
    input  logic              i_flush,
    output logic              o_if_valid,
    output logic [0:ADDR_W-1] o_if_pc,
    output logic [0:DATA_W-1] o_if_instr,
    output logic              o_if_fault,
    input  logic              i_if_ready
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t              r_state;
    logic                r_req;
    logic [0:ADDR_W-1]   r_addr;

    // Write stage in front of the queue. Results land here first and are
    // written into the queue on the following edge.
    logic                r_push_vld;
    logic [0:ADDR_W-1]   r_push_pc;
    logic [0:DATA_W-1]   r_push_instr;
    logic                r_push_fault;

    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_count;

    logic [0:ADDR_W-1]   r_mem_pc    [FIFO_DEPTH];
    logic [0:DATA_W-1]   r_mem_instr [FIFO_DEPTH];
    logic                r_mem_fault [FIFO_DEPTH];

    logic                w_pc_accept;
    logic                w_misaligned;
    logic                w_push;
    logic                w_pop;
    logic                w_q_valid;
    logic [CNT_W:0]      w_occupancy;

    // The entry in the write stage already owns a queue slot. Counting it
    // here stops a new fetch from being issued when no slot is left for it.
    assign w_occupancy  = {1'b0, r_count} + (CNT_W+1)'(r_push_vld);
    assign o_pc_ready   = i_rst_n && (r_state == S_IDLE) &&
                          (w_occupancy < (CNT_W+1)'(FIFO_DEPTH)) && !i_flush;
    assign w_pc_accept  = i_pc_valid && o_pc_ready;
    assign w_misaligned = |i_pc_in[ADDR_W-2:ADDR_W-1];

    assign w_q_valid    = (r_count != '0);
    assign w_push       = r_push_vld;
    assign w_pop        = w_q_valid && i_if_ready;

    assign o_imem_req   = r_req;
    assign o_imem_addr  = r_addr;

    // Head entry is gated with valid so that an empty queue shows all zeros.
    assign o_if_valid   = w_q_valid;
    assign o_if_pc      = w_q_valid ? r_mem_pc[r_rd_ptr]    : '0;
    assign o_if_instr   = w_q_valid ? r_mem_instr[r_rd_ptr] : '0;
    assign o_if_fault   = w_q_valid ? r_mem_fault[r_rd_ptr] : 1'b0;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // ------------------------------------------------------------------
    // Fetch FSM with registered request and write-stage outputs
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_push_vld   <= 1'b0;
            r_push_pc    <= '0;
            r_push_instr <= '0;
            r_push_fault <= 1'b0;
        end else begin
            r_push_vld <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // o_pc_ready is already low during a flush.
                    if (w_pc_accept) begin
                        if (w_misaligned) begin
                            r_push_vld   <= 1'b1;
                            r_push_pc    <= i_pc_in;
                            r_push_instr <= '0;
                            r_push_fault <= 1'b1;
                        end else begin
                            r_req   <= 1'b1;
                            r_addr  <= i_pc_in;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (i_imem_gnt) begin
                        // Once the read is granted it cannot be cancelled,
                        // so a flush must still wait to absorb its data.
                        r_req   <= 1'b0;
                        r_state <= i_flush ? S_DISCARD : S_WAIT;
                    end else if (i_flush) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        r_state <= S_IDLE;
                        if (!i_flush) begin
                            r_push_vld   <= 1'b1;
                            r_push_pc    <= r_addr;
                            r_push_instr <= i_imem_rdata;
                            r_push_fault <= 1'b0;
                        end
                    end else if (i_flush) begin
                        r_state <= S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (i_imem_rvalid) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output queue: pointers and count. A flush overrides push and pop.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Queue storage. It needs no reset because the outputs are gated by valid.
    always_ff @(posedge i_clk) begin
        if (w_push && !i_flush) begin
            r_mem_pc[r_wr_ptr]    <= r_push_pc;
            r_mem_instr[r_wr_ptr] <= r_push_instr;
            r_mem_fault[r_wr_ptr] <= r_push_fault;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//
// Directed scenarios plus a randomized stream for instr_fetch. The bench plays
// the instruction memory itself. Expected decode-side entries are kept in a
// queue model that follows the stage's externally visible rules:
//   - a result is visible one cycle after it is produced (after rvalid, or
//     after acceptance of a misaligned PC);
//   - the queue is FIFO;
//   - a flush clears everything.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [0:AW-1] pc_in;
    logic          pc_valid;
    logic          pc_ready;
    logic          imem_req;
    logic [0:AW-1] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [0:DW-1] imem_rdata;
    logic          flush;
    logic          if_valid;
    logic [0:AW-1] if_pc;
    logic [0:DW-1] if_instr;
    logic          if_fault;
    logic          if_ready;

    typedef struct packed {
        logic [0:31] pc;
        logic [0:31] instr;
        logic        fault;
    } ent_t;

    ent_t q[$];
    ent_t pend;
    ent_t sched;
    bit   pend_vld;
    bit   sched_vld;
    bit   rand_rdy;
    int   n_assert;
    int   n_fail;

    always #5 clk = ~clk;

    instr_fetch #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pc_in       (pc_in),
        .i_pc_valid    (pc_valid),
        .o_pc_ready    (pc_ready),
        .o_imem_req    (imem_req),
        .o_imem_addr   (imem_addr),
        .i_imem_gnt    (imem_gnt),
        .i_imem_rvalid (imem_rvalid),
        .i_imem_rdata  (imem_rdata),
        .i_flush       (flush),
        .o_if_valid    (if_valid),
        .o_if_pc       (if_pc),
        .o_if_instr    (if_instr),
        .o_if_fault    (if_fault),
        .i_if_ready    (if_ready)
    );

    // Memory contents: a fixed scramble of the address.
    function automatic logic [0:31] memf(input logic [0:31] a);
        logic [0:31] r;
        r = {a[16:31], a[0:15]} ^ 32'h1357_9BDF;
        return r;
    endfunction

    // Free space exists when queued plus about-to-appear entries are below DEPTH.
    function automatic bit exp_ready();
        return (q.size() + int'(pend_vld)) < DEPTH;
    endfunction

    task automatic chk(input string tag, input logic [0:31] obs, input logic [0:31] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Checks the head against the model before the edge,
    // then applies the edge to the model.
    task automatic step();
        bit pop;
        bit fl;
        if (rand_rdy) if_ready = 1'($urandom_range(0, 1));
        #3;
        chk("if_valid", {31'd0, if_valid}, {31'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("if_pc", if_pc, q[0].pc);
            chk("if_instr", if_instr, q[0].instr);
            chk("if_fault", {31'd0, if_fault}, {31'd0, q[0].fault});
        end
        pop = (q.size() != 0) && if_ready;
        fl  = flush;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            pend_vld = 1'b0;
        end else begin
            if (pop) void'(q.pop_front());
            if (pend_vld) q.push_back(pend);
            pend_vld = sched_vld;
            pend     = sched;
        end
        sched_vld = 1'b0;
    endtask

    // Full fetch of one PC. gdly = idle cycles before gnt, rdly = cycles from gnt to rvalid.
    task automatic fetch(input logic [0:31] a, input int gdly, input int rdly);
        int          n;
        logic [0:31] d;
        pc_in    = a;
        pc_valid = 1'b1;
        n        = 0;
        #1;
        while (!exp_ready()) begin
            chk("pc_ready_full", {31'd0, pc_ready}, 32'd0);
            step();
            #1;
            n++;
            if (n > 50) begin
                n_fail++;
                $error("FAIL wait_pc_ready observed=timeout expected=ready");
                break;
            end
        end
        chk("pc_ready", {31'd0, pc_ready}, 32'd1);
        if (|a[30:31]) begin
            sched     = '{pc: a, instr: 32'd0, fault: 1'b1};
            sched_vld = 1'b1;
            step();
            pc_valid = 1'b0;
            #1;
            chk("misaligned_no_req", {31'd0, imem_req}, 32'd0);
            return;
        end
        step();
        pc_valid = 1'b0;
        #1;
        for (int i = 0; i < gdly; i++) begin
            chk("req_held", {31'd0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, a);
            chk("pc_ready_busy", {31'd0, pc_ready}, 32'd0);
            step();
            #1;
        end
        chk("req", {31'd0, imem_req}, 32'd1);
        chk("addr", imem_addr, a);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        #1;
        chk("req_after_gnt", {31'd0, imem_req}, 32'd0);
        for (int i = 1; i < rdly; i++) step();
        d           = memf(a);
        imem_rvalid = 1'b1;
        imem_rdata  = d;
        sched       = '{pc: a, instr: d, fault: 1'b0};
        sched_vld   = 1'b1;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
    endtask

    task automatic drain();
        int n;
        rand_rdy = 1'b0;
        if_ready = 1'b1;
        n = 0;
        while ((q.size() != 0 || pend_vld) && n < 10) begin
            step();
            n++;
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [0:31] a;
        n_assert    = 0;
        n_fail      = 0;
        rand_rdy    = 1'b0;
        pend_vld    = 1'b0;
        sched_vld   = 1'b0;
        rst_n       = 1'b0;
        pc_in       = '0;
        pc_valid    = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        flush       = 1'b0;
        if_ready    = 1'b0;

        // Values while reset is held.
        #2;
        chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("rst_imem_addr", imem_addr, 32'd0);
        chk("rst_pc_ready", {31'd0, pc_ready}, 32'd0);
        chk("rst_if_pc", if_pc, 32'd0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Reset asserted in WAIT with one entry queued.
        if_ready = 1'b0;
        fetch(32'h0000_0002, 0, 1);
        pc_in    = 32'h0000_0100;
        pc_valid = 1'b1;
        #1;
        chk("pc_ready_before_rst", {31'd0, pc_ready}, 32'd1);
        step();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("pre_rst_if_valid", {31'd0, if_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_if_valid", {31'd0, if_valid}, 32'd0);
        chk("arst_if_pc", if_pc, 32'd0);
        chk("arst_if_instr", if_instr, 32'd0);
        chk("arst_if_fault", {31'd0, if_fault}, 32'd0);
        chk("arst_imem_req", {31'd0, imem_req}, 32'd0);
        chk("arst_imem_addr", imem_addr, 32'd0);
        chk("arst_pc_ready", {31'd0, pc_ready}, 32'd0);
        rst_n = 1'b1;
        q.delete();
        pend_vld  = 1'b0;
        sched_vld = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hCAFE_F00D;
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("post_rst_req", {31'd0, imem_req}, 32'd0);
        chk("post_rst_pc_ready", {31'd0, pc_ready}, 32'd1);
        step();
        step();

        // Stream 0x0, 0x4, 0x8 with gnt immediately and rvalid one cycle later.
        if_ready = 1'b1;
        fetch(32'h0, 0, 1);
        fetch(32'h4, 0, 1);
        fetch(32'h8, 0, 1);
        drain();

        // Backpressure: the queue fills and then frees exactly one slot.
        if_ready = 1'b0;
        fetch(32'h10, 0, 1);
        fetch(32'h14, 0, 1);
        step();
        #1;
        chk("bp_full_pc_ready", {31'd0, pc_ready}, 32'd0);
        step();
        #1;
        chk("bp_still_full", {31'd0, pc_ready}, 32'd0);
        chk("bp_head", if_pc, 32'h10);
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        #1;
        chk("bp_pc_ready_after_pop", {31'd0, pc_ready}, 32'd1);
        chk("bp_second", if_pc, 32'h14);
        drain();

        // Misaligned PC.
        if_ready = 1'b0;
        fetch(32'h6, 0, 1);
        chk("mis_not_yet", {31'd0, if_valid}, 32'd0);
        step();
        chk("mis_valid", {31'd0, if_valid}, 32'd1);
        chk("mis_fault", {31'd0, if_fault}, 32'd1);
        chk("mis_instr", if_instr, 32'd0);

        // Flush in IDLE clears the queue and blocks acceptance.
        pc_in    = 32'h30;
        pc_valid = 1'b1;
        flush    = 1'b1;
        #1;
        chk("flush_blocks_ready", {31'd0, pc_ready}, 32'd0);
        step();
        flush    = 1'b0;
        pc_valid = 1'b0;
        #1;
        chk("flush_idle_empty", {31'd0, if_valid}, 32'd0);
        chk("flush_idle_no_req", {31'd0, imem_req}, 32'd0);

        // Flush in WAIT: the returning data is dropped.
        if_ready = 1'b1;
        pc_in    = 32'h20;
        pc_valid = 1'b1;
        #1;
        chk("w_pc_ready", {31'd0, pc_ready}, 32'd1);
        step();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        flush    = 1'b1;
        step();
        flush       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        #1;
        chk("discard_pc_ready", {31'd0, pc_ready}, 32'd0);
        step();
        imem_rvalid = 1'b0;
        #1;
        chk("after_discard_ready", {31'd0, pc_ready}, 32'd1);
        step();
        fetch(32'h40, 1, 2);
        drain();

        // Flush in REQ with gnt low: the request is aborted.
        pc_in    = 32'h80;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        #1;
        chk("req_before_abort", {31'd0, imem_req}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        chk("abort_req_low", {31'd0, imem_req}, 32'd0);
        chk("abort_idle", {31'd0, pc_ready}, 32'd1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_2222;
        step();
        imem_rvalid = 1'b0;
        step();

        // Flush in REQ with gnt in the same cycle: goes through DISCARD.
        pc_in    = 32'h84;
        pc_valid = 1'b1;
        step();
        pc_valid = 1'b0;
        imem_gnt = 1'b1;
        flush    = 1'b1;
        step();
        imem_gnt = 1'b0;
        flush    = 1'b0;
        #1;
        chk("gnt_flush_discard", {31'd0, pc_ready}, 32'd0);
        chk("gnt_flush_req", {31'd0, imem_req}, 32'd0);
        step();
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h3333_4444;
        step();
        imem_rvalid = 1'b0;
        step();
        fetch(32'h88, 0, 1);
        drain();

        // Randomized stream with random handshake delays and backpressure.
        rand_rdy = 1'b1;
        for (int t = 0; t < 40; t++) begin
            a = $urandom;
            if ($urandom_range(0, 3) == 0) begin
                a[30:31] = 2'($urandom_range(1, 3));
            end else begin
                a[30:31] = 2'b00;
            end
            fetch(a, int'($urandom_range(0, 2)), int'($urandom_range(1, 3)));
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
